// File: rtl/axi_xbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_xbar_pkg                                                               |
// | Shared AXI widths, slave address map and AR crossbar state encoding.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package axi_xbar_pkg;

   localparam int AXI_NUM_M   = 2;
   localparam int AXI_NUM_S   = 5;
   localparam int AXI_ID_W    = 4;
   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_LEN_W   = 4;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_MAX_OUT = 4;

   // Each slave owns one 64 KiB window: slave s lives at 0x000s_0000.
   localparam logic [AXI_ADDR_W-1:0] SLV_BASE [AXI_NUM_S] = '{
      32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000
   };
   localparam logic [AXI_ADDR_W-1:0] SLV_MASK [AXI_NUM_S] = '{
      32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_DECERR = 2'd2
   } ar_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | One-hot round-robin grant; pointer moves past the winner on advance.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] r_ptr;
   logic             w_found;
   logic [IDX_W-1:0] w_ptr_nxt;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = int'(r_ptr) + i;
         if (k >= N) k = k - N;
         if (!w_found && req[k]) begin
            grant[k]  = 1'b1;
            grant_idx = IDX_W'(k);
            w_found   = 1'b1;
         end
      end
   end

   assign w_ptr_nxt = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (advance && w_found) begin
         r_ptr <= w_ptr_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_ar_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_ar_xbar                                                                |
// | AXI AR crossbar: round-robin master pick, single request slot, decode.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_ar_xbar
   import axi_xbar_pkg::*;
#(
   parameter int NUM_M   = AXI_NUM_M,
   parameter int NUM_S   = AXI_NUM_S,
   parameter int ID_W    = AXI_ID_W,
   parameter int ADDR_W  = AXI_ADDR_W,
   parameter int LEN_W   = AXI_LEN_W,
   parameter int SIZE_W  = AXI_SIZE_W,
   parameter int MAX_OUT = AXI_MAX_OUT,
   parameter int IDS_W   = ID_W + $clog2(NUM_M)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_M-1:0][ID_W-1:0]    arid_m,
   input  logic [NUM_M-1:0][ADDR_W-1:0]  araddr_m,
   input  logic [NUM_M-1:0][LEN_W-1:0]   arlen_m,
   input  logic [NUM_M-1:0][SIZE_W-1:0]  arsize_m,
   input  logic [NUM_M-1:0][1:0]         arburst_m,
   input  logic [NUM_M-1:0]              arvalid_m,
   output logic [NUM_M-1:0]              arready_m,
   output logic [IDS_W-1:0]              arid_s,
   output logic [ADDR_W-1:0]             araddr_s,
   output logic [LEN_W-1:0]              arlen_s,
   output logic [SIZE_W-1:0]             arsize_s,
   output logic [1:0]                    arburst_s,
   output logic [NUM_S-1:0]              arvalid_s,
   input  logic [NUM_S-1:0]              arready_s,
   input  logic [NUM_S-1:0]              rdone_s,
   output logic                          decerr_valid,
   output logic [IDS_W-1:0]              decerr_id,
   input  logic                          decerr_ready
);

   localparam int IDX_W = $clog2(NUM_M);
   localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   ar_state_e         r_state;
   ar_state_e         w_state_nxt;
   logic [NUM_M-1:0]  w_req;
   logic [NUM_M-1:0]  w_grant;
   logic [IDX_W-1:0]  w_gidx;
   logic              w_take;
   logic              w_slv_hs;
   logic              w_dec_hit;
   logic [SEL_W-1:0]  w_dec_sel;
   logic [ADDR_W-1:0] w_addr;

   logic [IDS_W-1:0]  r_arid;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [SIZE_W-1:0] r_size;
   logic [1:0]        r_burst;
   logic [SEL_W-1:0]  r_sel;

   // Only IDLE offers the slot; grant is a pure function of arvalid_m, state, pointer.
   assign w_req  = (r_state == ST_IDLE) ? arvalid_m : '0;
   assign w_take = rst && (|w_req);

   rr_arbiter #(
      .N     (NUM_M),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (w_req),
      .advance   (w_take),
      .grant     (w_grant),
      .grant_idx (w_gidx)
   );

   assign arready_m = {NUM_M{rst}} & w_grant;
   assign w_addr    = araddr_m[w_gidx];

   always_comb begin
      w_dec_hit = 1'b0;
      w_dec_sel = '0;
      // Descending scan so the lowest-index match is the one left standing.
      for (int s = NUM_S - 1; s >= 0; s--) begin
         if ((w_addr & ADDR_W'(SLV_MASK[s])) == ADDR_W'(SLV_BASE[s])) begin
            w_dec_hit = 1'b1;
            w_dec_sel = SEL_W'(s);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_arid  <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_sel   <= '0;
      end else if (w_take) begin
         r_arid  <= {w_gidx, arid_m[w_gidx]};
         r_addr  <= w_addr;
         r_len   <= arlen_m[w_gidx];
         r_size  <= arsize_m[w_gidx];
         r_burst <= arburst_m[w_gidx];
         r_sel   <= w_dec_sel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_slv_hs = |(arvalid_s & arready_s);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_take) w_state_nxt = w_dec_hit ? ST_HOLD : ST_DECERR;
         ST_HOLD:   if (w_slv_hs) w_state_nxt = ST_IDLE;
         ST_DECERR: if (decerr_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   generate
      for (genvar s = 0; s < NUM_S; s++) begin : g_slv
         logic [CNT_W-1:0] r_out_cnt;
         logic             w_inc;
         logic             w_dec;

         assign arvalid_s[s] = (r_state == ST_HOLD) && (r_sel == SEL_W'(s)) &&
                               (r_out_cnt < CNT_W'(MAX_OUT));
         assign w_inc = arvalid_s[s] && arready_s[s];
         assign w_dec = rdone_s[s] && (r_out_cnt != '0);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_out_cnt <= '0;
            end else if (w_inc && !w_dec) begin
               r_out_cnt <= r_out_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
               r_out_cnt <= r_out_cnt - CNT_W'(1);
            end
         end
      end
   endgenerate

   assign arid_s       = r_arid;
   assign araddr_s     = r_addr;
   assign arlen_s      = r_len;
   assign arsize_s     = r_size;
   assign arburst_s    = r_burst;
   assign decerr_valid = (r_state == ST_DECERR);
   assign decerr_id    = r_arid;

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_ar_xbar                                                             |
// | Directed table plus hand-written sequences for the AR crossbar.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_ar_xbar;

   logic             clk;
   logic             rst;
   logic [1:0][3:0]  arid_m;
   logic [1:0][31:0] araddr_m;
   logic [1:0][3:0]  arlen_m;
   logic [1:0][2:0]  arsize_m;
   logic [1:0][1:0]  arburst_m;
   logic [1:0]       arvalid_m;
   logic [1:0]       arready_m;
   logic [4:0]       arid_s;
   logic [31:0]      araddr_s;
   logic [3:0]       arlen_s;
   logic [2:0]       arsize_s;
   logic [1:0]       arburst_s;
   logic [4:0]       arvalid_s;
   logic [4:0]       arready_s;
   logic [4:0]       rdone_s;
   logic             decerr_valid;
   logic [4:0]       decerr_id;
   logic             decerr_ready;

   int checks = 0;
   int errors = 0;

   axi_ar_xbar dut (
      .clk          (clk),
      .rst          (rst),
      .arid_m       (arid_m),
      .araddr_m     (araddr_m),
      .arlen_m      (arlen_m),
      .arsize_m     (arsize_m),
      .arburst_m    (arburst_m),
      .arvalid_m    (arvalid_m),
      .arready_m    (arready_m),
      .arid_s       (arid_s),
      .araddr_s     (araddr_s),
      .arlen_s      (arlen_s),
      .arsize_s     (arsize_s),
      .arburst_s    (arburst_s),
      .arvalid_s    (arvalid_s),
      .arready_s    (arready_s),
      .rdone_s      (rdone_s),
      .decerr_valid (decerr_valid),
      .decerr_id    (decerr_id),
      .decerr_ready (decerr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [3:0]  id;
      logic [31:0] addr;
      int          slv;   // -1 marks an unmapped address
      logic [4:0]  eid;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      arvalid_m    = '0;
      arready_s    = '0;
      rdone_s      = '0;
      decerr_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   // One request from master m; checks grant, then the slot one cycle later.
   task automatic xfer(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input int slv, input logic [4:0] eid, input logic rd,
                       input logic expv, input string nm);
      @(negedge clk);
      arid_m[m]    = id;
      araddr_m[m]  = addr;
      arvalid_m[m] = 1'b1;
      #1 chk({nm, " arready_m"}, 32'(arready_m), 32'(1) << m);
      @(negedge clk);
      arvalid_m[m] = 1'b0;
      #1;
      chk({nm, " arid_s"}, 32'(arid_s), 32'(eid));
      chk({nm, " araddr_s"}, araddr_s, addr);
      chk({nm, " arready_m_hold"}, 32'(arready_m), 32'd0);
      if (slv >= 0) begin
         chk({nm, " arvalid_s"}, 32'(arvalid_s), expv ? (32'(1) << slv) : 32'd0);
         chk({nm, " decerr_valid"}, 32'(decerr_valid), 32'd0);
         arready_s[slv] = 1'b1;
         rdone_s[slv]   = rd;
         @(negedge clk);
         arready_s = '0;
         rdone_s   = '0;
      end else begin
         chk({nm, " decerr_valid"}, 32'(decerr_valid), 32'd1);
         chk({nm, " decerr_id"}, 32'(decerr_id), 32'(eid));
         chk({nm, " arvalid_s"}, 32'(arvalid_s), 32'd0);
         decerr_ready = 1'b1;
         @(negedge clk);
         decerr_ready = 1'b0;
      end
   endtask

   initial begin
      tbl[0] = '{m: 0, id: 4'h3, addr: 32'h0001_0000, slv:  1, eid: 5'h03};
      tbl[1] = '{m: 1, id: 4'h5, addr: 32'h0002_0040, slv:  2, eid: 5'h15};
      tbl[2] = '{m: 0, id: 4'hF, addr: 32'h0004_FFFC, slv:  4, eid: 5'h0F};
      tbl[3] = '{m: 1, id: 4'h0, addr: 32'h0000_0000, slv:  0, eid: 5'h10};
      tbl[4] = '{m: 1, id: 4'h7, addr: 32'hFFFF_0000, slv: -1, eid: 5'h17};
      tbl[5] = '{m: 0, id: 4'h9, addr: 32'h0005_0000, slv: -1, eid: 5'h09};
      tbl[6] = '{m: 1, id: 4'hA, addr: 32'h0003_1234, slv:  3, eid: 5'h1A};

      arid_m    = '0;
      araddr_m  = '0;
      arlen_m   = {4'h7, 4'h3};
      arsize_m  = {3'h2, 3'h2};
      arburst_m = {2'b01, 2'b01};
      do_reset();

      // Reset state with masters idle
      #1;
      chk("rst arvalid_s", 32'(arvalid_s), 32'd0);
      chk("rst arready_m", 32'(arready_m), 32'd0);
      chk("rst decerr_valid", 32'(decerr_valid), 32'd0);
      chk("rst arid_s", 32'(arid_s), 32'd0);
      chk("rst araddr_s", araddr_s, 32'd0);

      for (int i = 0; i < 7; i++) begin
         xfer(tbl[i].m, tbl[i].id, tbl[i].addr, tbl[i].slv, tbl[i].eid, 1'b1, 1'b1,
              $sformatf("vec%0d", i));
      end
      chk("vec arlen_s", 32'(arlen_s), 32'h7);

      // Both masters valid, slaves always ready: grants alternate
      do_reset();
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         if (g == 0) begin
            arid_m    = {4'h5, 4'h2};
            araddr_m  = {32'h0001_0200, 32'h0000_0100};
            arvalid_m = 2'b11;
            arready_s = '1;
         end
         #1 chk($sformatf("alt%0d arready_m", g), 32'(arready_m), (g % 2 == 0) ? 32'd1 : 32'd2);
         @(negedge clk);
         #1;
         chk($sformatf("alt%0d arvalid_s", g), 32'(arvalid_s), (g % 2 == 0) ? 32'h01 : 32'h02);
         chk($sformatf("alt%0d arid_s", g), 32'(arid_s), (g % 2 == 0) ? 32'h02 : 32'h15);
      end

      // Outstanding limit on slave 2
      do_reset();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k == 0) begin
            arid_m[0]    = 4'h1;
            araddr_m[0]  = 32'h0002_0000;
            arvalid_m[0] = 1'b1;
            arready_s    = 5'b00100;
         end
         #1;
         if (k % 2 == 0) chk($sformatf("lim%0d arready_m", k), 32'(arready_m), 32'd1);
         else chk($sformatf("lim%0d arvalid_s", k), 32'(arvalid_s), 32'h04);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         arvalid_m = '0;
         #1;
         chk($sformatf("lim_hold%0d arvalid_s", k), 32'(arvalid_s), 32'd0);
         chk($sformatf("lim_hold%0d arready_m", k), 32'(arready_m), 32'd0);
      end
      @(negedge clk);
      rdone_s[2] = 1'b1;
      #1 chk("lim_rdone arvalid_s", 32'(arvalid_s), 32'd0);
      @(negedge clk);
      rdone_s = '0;
      #1 chk("lim_release arvalid_s", 32'(arvalid_s), 32'h04);
      @(negedge clk);
      arready_s = '0;

      // Same-cycle rdone and handshake at count 2 keeps the count at 2
      do_reset();
      xfer(0, 4'h1, 32'h0000_0010, 0, 5'h01, 1'b0, 1'b1, "sim_a");
      xfer(0, 4'h1, 32'h0000_0020, 0, 5'h01, 1'b0, 1'b1, "sim_b");
      xfer(0, 4'h1, 32'h0000_0030, 0, 5'h01, 1'b1, 1'b1, "sim_c");
      xfer(0, 4'h1, 32'h0000_0040, 0, 5'h01, 1'b0, 1'b1, "sim_d");
      xfer(0, 4'h1, 32'h0000_0050, 0, 5'h01, 1'b0, 1'b1, "sim_e");
      xfer(0, 4'h1, 32'h0000_0060, 0, 5'h01, 1'b0, 1'b0, "sim_f");

      // Decode error held while decerr_ready is low
      do_reset();
      @(negedge clk);
      arid_m[1]    = 4'h7;
      araddr_m[1]  = 32'hFFFF_0000;
      arvalid_m[1] = 1'b1;
      #1 chk("de grant", 32'(arready_m), 32'd2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         araddr_m[0] = 32'h0000_0000;
         arvalid_m   = 2'b11;
         #1;
         chk($sformatf("de%0d decerr_valid", k), 32'(decerr_valid), 32'd1);
         chk($sformatf("de%0d decerr_id", k), 32'(decerr_id), 32'h17);
         chk($sformatf("de%0d arready_m", k), 32'(arready_m), 32'd0);
         chk($sformatf("de%0d arvalid_s", k), 32'(arvalid_s), 32'd0);
      end
      @(negedge clk);
      decerr_ready = 1'b1;
      @(negedge clk);
      decerr_ready = 1'b0;
      #1;
      chk("de_done decerr_valid", 32'(decerr_valid), 32'd0);
      chk("de_done arready_m", 32'(arready_m), 32'd1);

      // Reset while in HOLD
      do_reset();
      xfer(0, 4'h2, 32'h0001_0000, 1, 5'h02, 1'b0, 1'b1, "rh_a");
      @(negedge clk);
      araddr_m[0]  = 32'h0001_0004;
      arvalid_m[0] = 1'b1;
      @(negedge clk);
      araddr_m[1] = 32'h0000_0000;
      arvalid_m   = 2'b11;
      #1 chk("rh hold arvalid_s", 32'(arvalid_s), 32'h02);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rh in_rst arvalid_s", 32'(arvalid_s), 32'd0);
      chk("rh in_rst arready_m", 32'(arready_m), 32'd0);
      @(negedge clk);
      rst         = 1'b1;
      araddr_m[0] = 32'h0001_0008;
      #1 chk("rh first grant", 32'(arready_m), 32'd1);
      @(negedge clk);
      arvalid_m = '0;
      arready_s = 5'b00010;
      #1 chk("rh post arvalid_s", 32'(arvalid_s), 32'h02);
      @(negedge clk);
      arready_s = '0;
      xfer(0, 4'h2, 32'h0001_0010, 1, 5'h02, 1'b0, 1'b1, "rh_b");
      xfer(0, 4'h2, 32'h0001_0020, 1, 5'h02, 1'b0, 1'b1, "rh_c");
      xfer(0, 4'h2, 32'h0001_0030, 1, 5'h02, 1'b0, 1'b1, "rh_d");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
